display_mode_scheduler: RTL

//  Frame-synchronous controller for the VGA image path: debounces board switches and decides image

---
 rtl/display_mode_scheduler_pkg.sv | 25 ++
 rtl/switch_debouncer.sv | 32 +++
 rtl/display_mode_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/display_mode_scheduler_pkg.sv
// Shared types and helpers for the display mode scheduler: FSM encoding,
// fade ceiling and small width/index helpers.
package display_mode_scheduler_pkg;

    typedef enum logic [1:0] {
        SHOW     = 2'd0,
        FADE_OUT = 2'd1,
        SWAP     = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

    function automatic int fade_max(input int level_w);
        return (1 << level_w) - 1;
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int wrap_inc(input int idx, input int num);
        return (idx >= num - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Single-switch debouncer: the clean value follows raw only after CYCLES
// consecutive samples that disagree with it.
module switch_debouncer
    import display_mode_scheduler_pkg::*;
#(
    parameter int CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    localparam int CW = cnt_width(CYCLES);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            clean <= 1'b0;
        end else if (raw == clean) begin
            cnt <= '0;
        end else if (cnt == CW'(CYCLES - 1)) begin
            clean <= raw;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/display_mode_scheduler.sv
// Frame-synchronous image select / inversion / fade controller for the VGA
// pixel path. Every output change lands on a frame_tick (vsync falling edge).
//
// state    | meaning
// SHOW     | full brightness, waiting for a pending request at frame start
// FADE_OUT | stepping fade_level down to 0
// SWAP     | fully dark, img_sel takes the target on the next frame_tick
// FADE_IN  | stepping fade_level back up to FADE_MAX
module display_mode_scheduler
    import display_mode_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int DWELL_FRAMES     = 300,
    parameter int FADE_STEP_FRAMES = 2,
    parameter int NUM_IMAGES       = 2,
    parameter int LEVEL_W          = 4,
    localparam int IMG_W           = cnt_width(NUM_IMAGES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_img,
    input  logic               sw_inv,
    input  logic               sw_auto,
    input  logic               vsync,
    output logic [IMG_W-1:0]   img_sel,
    output logic               invert_en,
    output logic [LEVEL_W-1:0] fade_level,
    output logic               busy,
    output logic               frame_tick
);

    localparam logic [LEVEL_W-1:0] FADE_MAX = LEVEL_W'(fade_max(LEVEL_W));
    localparam int DW = cnt_width(DWELL_FRAMES);
    localparam int SW = cnt_width(FADE_STEP_FRAMES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(FADE_STEP_FRAMES - 1);

    logic img_clean, inv_clean, auto_clean;

    switch_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_img
        (.clk(clk), .reset(reset), .raw(sw_img), .clean(img_clean));
    switch_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_inv
        (.clk(clk), .reset(reset), .raw(sw_inv), .clean(inv_clean));
    switch_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_db_auto
        (.clk(clk), .reset(reset), .raw(sw_auto), .clean(auto_clean));

    state_t           state;
    logic             vsync_q;
    logic             pending;
    logic             pend_manual;
    logic [IMG_W-1:0] pend_target;
    logic [IMG_W-1:0] tgt_img;
    logic [DW-1:0]    dwell_cnt;
    logic [SW-1:0]    step_cnt;

    logic [IMG_W-1:0] committed;
    logic [IMG_W-1:0] man_target;
    logic [IMG_W-1:0] auto_target;
    logic             man_req;
    logic             auto_req;

    // Compare the switch against the image already in flight, so a sequence
    // under way does not re-request its own target.
    always_comb begin
        committed   = (state == FADE_OUT || state == SWAP) ? tgt_img : img_sel;
        man_target  = IMG_W'(img_clean);
        auto_target = IMG_W'(wrap_inc(int'(img_sel), NUM_IMAGES));
        man_req     = !auto_clean && (man_target != committed)
                      && !(pending && pend_target == man_target);
        auto_req    = auto_clean && frame_tick && (state == SHOW)
                      && (dwell_cnt == DWELL_LAST) && !(pending && pend_manual);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SHOW;
            vsync_q     <= 1'b0;
            frame_tick  <= 1'b0;
            img_sel     <= '0;
            invert_en   <= 1'b0;
            fade_level  <= FADE_MAX;
            busy        <= 1'b0;
            pending     <= 1'b0;
            pend_manual <= 1'b0;
            pend_target <= '0;
            tgt_img     <= '0;
            dwell_cnt   <= '0;
            step_cnt    <= '0;
        end else begin
            vsync_q    <= vsync;
            frame_tick <= vsync_q & ~vsync;

            if (frame_tick) invert_en <= inv_clean;

            if (man_req) begin
                dwell_cnt <= '0;
            end else if (frame_tick && state == SHOW) begin
                dwell_cnt <= (dwell_cnt == DWELL_LAST) ? '0 : dwell_cnt + DW'(1);
            end

            case (state)
                SHOW: begin
                    fade_level <= FADE_MAX;
                    if (frame_tick && pending) begin
                        state    <= FADE_OUT;
                        busy     <= 1'b1;
                        tgt_img  <= pend_target;
                        step_cnt <= STEP_LAST;
                        pending  <= 1'b0;
                    end
                end
                FADE_OUT: begin
                    if (frame_tick) begin
                        if (step_cnt == '0) begin
                            step_cnt <= STEP_LAST;
                            if (fade_level != '0) fade_level <= fade_level - LEVEL_W'(1);
                            if (fade_level <= LEVEL_W'(1)) state <= SWAP;
                        end else begin
                            step_cnt <= step_cnt - SW'(1);
                        end
                    end
                end
                SWAP: begin
                    if (frame_tick) begin
                        img_sel  <= tgt_img;
                        state    <= FADE_IN;
                        step_cnt <= STEP_LAST;
                    end
                end
                FADE_IN: begin
                    if (frame_tick) begin
                        if (step_cnt == '0) begin
                            step_cnt <= STEP_LAST;
                            if (fade_level != FADE_MAX) fade_level <= fade_level + LEVEL_W'(1);
                            if (fade_level >= FADE_MAX - LEVEL_W'(1)) begin
                                state     <= SHOW;
                                busy      <= 1'b0;
                                dwell_cnt <= '0;
                            end
                        end else begin
                            step_cnt <= step_cnt - SW'(1);
                        end
                    end
                end
                default: state <= SHOW;
            endcase

            // Latching last lets a new request survive the edge that hands the old one to FADE_OUT.
            if (man_req) begin
                pending     <= 1'b1;
                pend_manual <= 1'b1;
                pend_target <= man_target;
            end else if (auto_req) begin
                pending     <= 1'b1;
                pend_manual <= 1'b0;
                pend_target <= auto_target;
            end
        end
    end

endmodule
